// File: rtl/bit_shift_pkg.sv
// bit_shift_engine shared types
// Mode and FSM encodings, default LFSR taps.
package bit_shift_pkg;

  typedef enum logic [1:0] {
    MODE_SHL  = 2'd0,
    MODE_SHR  = 2'd1,
    MODE_ROL  = 2'd2,
    MODE_LFSR = 2'd3
  } mode_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [7:0]  TAPS_8  = 8'hB8;
  localparam logic [15:0] TAPS_16 = 16'hB400;
  localparam logic [31:0] TAPS_32 = 32'h80200003;

  // Maximal-length taps for the common widths; 8-bit taps otherwise.
  function automatic logic [31:0] default_taps(input int w);
    logic [31:0] t;
    t = {24'h0, TAPS_8};
    if (w == 16) t = {16'h0, TAPS_16};
    if (w == 32) t = TAPS_32;
    return t;
  endfunction

endpackage

// File: rtl/bit_shift_step.sv
// bit_shift_engine single-step function
// Next register value and shifted-out bit for one shift.
module bit_shift_step
  import bit_shift_pkg::*;
#(
  parameter int              WIDTH = 8,
  parameter logic [WIDTH-1:0] TAPS = WIDTH'(default_taps(WIDTH))
) (
  input  logic [WIDTH-1:0] q,
  input  mode_t            mode,
  input  logic             serial_in,
  output logic [WIDTH-1:0] q_next,
  output logic             serial_out
);

  // Select the shift rule; an all-zero LFSR is kicked back to 1.
  always_comb begin
    q_next     = q;
    serial_out = 1'b0;
    unique case (1'b1)
      (mode == MODE_SHL): begin
        q_next     = {q[WIDTH-2:0], serial_in};
        serial_out = q[WIDTH-1];
      end
      (mode == MODE_SHR): begin
        q_next     = {serial_in, q[WIDTH-1:1]};
        serial_out = q[0];
      end
      (mode == MODE_ROL): begin
        q_next     = {q[WIDTH-2:0], q[WIDTH-1]};
        serial_out = q[WIDTH-1];
      end
      (mode == MODE_LFSR): begin
        if (q == '0) begin
          q_next     = WIDTH'(1);
          serial_out = 1'b0;
        end else begin
          q_next     = (q >> 1) ^ (q[0] ? TAPS : '0);
          serial_out = q[0];
        end
      end
      default: begin
        q_next     = q;
        serial_out = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/bit_shift_engine.sv
// bit_shift_engine top
// Shift register with counted runs, parallel load and LFSR mode.
module bit_shift_engine
  import bit_shift_pkg::*;
#(
  parameter int               WIDTH       = 8,
  parameter int               COUNT_W     = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE = WIDTH'(1),
  parameter logic [WIDTH-1:0] LFSR_TAPS   = WIDTH'(default_taps(WIDTH))
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_load,
  input  logic [WIDTH-1:0]   i_load_data,
  input  logic [1:0]         i_mode,
  input  logic               i_start,
  input  logic [COUNT_W-1:0] i_count,
  input  logic               i_serial_in,
  output logic [WIDTH-1:0]   o_data,
  output logic               o_serial_out,
  output logic               o_busy,
  output logic               o_done
);

  state_t             state_q, state_d;
  mode_t              mode_q, mode_d;
  logic [COUNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0]   data_q, data_d;
  logic               so_q, so_d;
  logic [WIDTH-1:0]   step_q;
  logic               step_so;

  bit_shift_step #(
    .WIDTH (WIDTH),
    .TAPS  (LFSR_TAPS)
  ) u_step (
    .q          (data_q),
    .mode       (mode_q),
    .serial_in  (i_serial_in),
    .q_next     (step_q),
    .serial_out (step_so)
  );

  // State, count, latched mode and shift register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
      mode_q  <= MODE_SHL;
      cnt_q   <= '0;
      data_q  <= RESET_VALUE;
      so_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      so_q    <= so_d;
    end
  end

  // Next-state: load/start in IDLE, one shift per RUN cycle.
  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    so_d    = so_q;
    unique case (state_q)
      ST_IDLE: begin
        if (i_load) begin
          data_d = i_load_data;
        end else if (i_start) begin
          mode_d = mode_t'(i_mode);
          cnt_d  = i_count;
          if (i_count == '0) state_d = ST_DONE;
          else               state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        data_d = step_q;
        so_d   = step_so;
        cnt_d  = cnt_q - COUNT_W'(1);
        if (cnt_q == COUNT_W'(1)) state_d = ST_DONE;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign o_data       = data_q;
  assign o_serial_out = so_q;
  assign o_busy       = (state_q == ST_RUN);
  assign o_done       = (state_q == ST_DONE);

endmodule

// File: tb/tb_bit_shift_engine.sv
// bit_shift_engine directed testbench
// Hand-computed vectors, one checking task.
module tb_bit_shift_engine;

  logic       i_clk;
  logic       i_rst_n;
  logic       i_load;
  logic [7:0] i_load_data;
  logic [1:0] i_mode;
  logic       i_start;
  logic [7:0] i_count;
  logic       i_serial_in;
  logic [7:0] o_data;
  logic       o_serial_out;
  logic       o_busy;
  logic       o_done;

  int n_tests = 0;
  int n_fail  = 0;

  bit_shift_engine dut (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_load       (i_load),
    .i_load_data  (i_load_data),
    .i_mode       (i_mode),
    .i_start      (i_start),
    .i_count      (i_count),
    .i_serial_in  (i_serial_in),
    .o_data       (o_data),
    .o_serial_out (o_serial_out),
    .o_busy       (o_busy),
    .o_done       (o_done)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic load(input logic [7:0] v);
    i_load = 1'b1;
    i_load_data = v;
    @(negedge i_clk);
    i_load = 1'b0;
  endtask

  // Called at a negedge with start already dropped; returns at the
  // negedge where done is seen (offset counted from the start edge).
  task automatic wait_done(output int done_at, output int busy_n);
    done_at = -1;
    busy_n  = 0;
    for (int k = 0; k < 300; k++) begin
      if (o_busy) busy_n++;
      if (o_done) begin
        done_at = k;
        break;
      end
      @(negedge i_clk);
    end
    if (done_at < 0) check("done_timeout", 0, 1);
  endtask

  task automatic run(input logic [1:0] m, input logic [7:0] n,
                     input logic sin,
                     output int done_at, output int busy_n);
    i_mode = m;
    i_count = n;
    i_serial_in = sin;
    i_start = 1'b1;
    @(negedge i_clk);
    i_start = 1'b0;
    wait_done(done_at, busy_n);
  endtask

  int d_at, b_n, hits;

  initial begin
    i_rst_n = 1'b0;
    i_load = 1'b0;
    i_load_data = '0;
    i_mode = '0;
    i_start = 1'b0;
    i_count = '0;
    i_serial_in = 1'b0;
    repeat (3) @(negedge i_clk);
    i_rst_n = 1'b1;
    @(negedge i_clk);
    check("rst_data", o_data, 8'h01);
    check("rst_busy", o_busy, 0);
    check("rst_done", o_done, 0);
    check("rst_so", o_serial_out, 0);

    // SHL 0x81 x3, serial_in=1, cycle by cycle
    load(8'h81);
    i_mode = 2'd0; i_count = 8'd3; i_serial_in = 1'b1; i_start = 1'b1;
    @(negedge i_clk);
    i_start = 1'b0;
    check("shl_e0_data", o_data, 8'h81);
    check("shl_e0_busy", o_busy, 1);
    @(negedge i_clk);
    check("shl_e1_data", o_data, 8'h03);
    check("shl_e1_so", o_serial_out, 1);
    check("shl_e1_busy", o_busy, 1);
    @(negedge i_clk);
    check("shl_e2_data", o_data, 8'h07);
    check("shl_e2_so", o_serial_out, 0);
    check("shl_e2_busy", o_busy, 1);
    @(negedge i_clk);
    check("shl_e3_data", o_data, 8'h0F);
    check("shl_e3_so", o_serial_out, 0);
    check("shl_e3_busy", o_busy, 0);
    check("shl_e3_done", o_done, 1);
    @(negedge i_clk);
    check("shl_e4_done", o_done, 0);
    check("shl_e4_data", o_data, 8'h0F);

    // LFSR from reset value
    i_rst_n = 1'b0;
    @(negedge i_clk);
    i_rst_n = 1'b1;
    @(negedge i_clk);
    i_mode = 2'd3; i_count = 8'd3; i_start = 1'b1;
    @(negedge i_clk);
    i_start = 1'b0;
    @(negedge i_clk);
    check("lfsr_1", o_data, 8'hB8);
    check("lfsr_1_so", o_serial_out, 1);
    @(negedge i_clk);
    check("lfsr_2", o_data, 8'h5C);
    @(negedge i_clk);
    check("lfsr_3", o_data, 8'h2E);
    check("lfsr_3_done", o_done, 1);
    @(negedge i_clk);

    // LFSR lock-up escape
    load(8'h00);
    run(2'd3, 8'd1, 1'b0, d_at, b_n);
    check("lfsr_zero", o_data, 8'h01);
    check("lfsr_zero_so", o_serial_out, 0);
    @(negedge i_clk);

    // ROL full turn
    load(8'h81);
    run(2'd2, 8'd8, 1'b0, d_at, b_n);
    check("rol8_data", o_data, 8'h81);
    check("rol8_done_at", d_at, 8);
    check("rol8_busy_n", b_n, 8);
    @(negedge i_clk);

    // SHR with zero fill
    load(8'hF0);
    run(2'd1, 8'd4, 1'b0, d_at, b_n);
    check("shr4_data", o_data, 8'h0F);
    check("shr4_so", o_serial_out, 0);
    @(negedge i_clk);

    // count = 0
    run(2'd0, 8'd0, 1'b1, d_at, b_n);
    check("cnt0_done_at", d_at, 0);
    check("cnt0_busy_n", b_n, 0);
    check("cnt0_data", o_data, 8'h0F);
    @(negedge i_clk);
    check("cnt0_done_drop", o_done, 0);

    // load beats start in the same cycle
    i_load = 1'b1; i_load_data = 8'h55;
    i_start = 1'b1; i_mode = 2'd0; i_count = 8'd2;
    @(negedge i_clk);
    i_load = 1'b0; i_start = 1'b0;
    check("ldst_data", o_data, 8'h55);
    check("ldst_busy", o_busy, 0);
    check("ldst_done", o_done, 0);
    @(negedge i_clk);
    check("ldst_done2", o_done, 0);
    check("ldst_data2", o_data, 8'h55);

    // load/start during RUN ignored
    load(8'h0F);
    i_mode = 2'd0; i_count = 8'd4; i_serial_in = 1'b0; i_start = 1'b1;
    @(negedge i_clk);
    i_start = 1'b1; i_load = 1'b1; i_load_data = 8'hAA;
    i_mode = 2'd3; i_count = 8'd1;
    @(negedge i_clk);
    i_start = 1'b0; i_load = 1'b0;
    wait_done(d_at, b_n);
    check("runign_data", o_data, 8'hF0);
    @(negedge i_clk);

    // reset mid-run: immediate, no done afterwards
    load(8'h3C);
    i_mode = 2'd2; i_count = 8'd10; i_start = 1'b1;
    @(negedge i_clk);
    i_start = 1'b0;
    repeat (3) @(negedge i_clk);
    #2 i_rst_n = 1'b0;
    #1;
    check("mrst_data", o_data, 8'h01);
    check("mrst_busy", o_busy, 0);
    check("mrst_done", o_done, 0);
    check("mrst_so", o_serial_out, 0);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    hits = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge i_clk);
      if (o_done || o_busy) hits++;
    end
    check("mrst_no_done", hits, 0);
    check("mrst_hold", o_data, 8'h01);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/bit_shift_engine.md
Name: bit_shift_engine

Overview:
Parametrised successor to the fixed 8-bit shift test block. It is a WIDTH-bit shift register with runtime-selectable mode: shift left, shift right, rotate left, or Galois LFSR. It has parallel load, serial in/out, and a counted-run handshake (start/busy/done). It serves as a pattern/PRBS source and data shifter in the DPM datapath and test benches.

Parameters:
WIDTH, 8, register width in bits (>=2)
COUNT_W, 8, width of shift-count input
RESET_VALUE, 8'h01, register value after reset (WIDTH bits)
LFSR_TAPS, 8'hB8, Galois feedback mask XORed in when the shifted-out LSB is 1 (WIDTH bits)

Ports:
i_clk  in  1  clock; all logic rising-edge
i_rst_n  in  1  asynchronous active-low reset
i_load  in  1  parallel-load strobe
i_load_data  in  WIDTH  parallel load value
i_mode  in  2  0=SHL, 1=SHR, 2=ROL, 3=LFSR; sampled at start
i_start  in  1  start a run of i_count shifts
i_count  in  COUNT_W  number of shifts in the run; sampled at start
i_serial_in  in  1  fill bit for SHL/SHR
o_data  out  WIDTH  shift register contents
o_serial_out  out  1  bit shifted out by the most recent shift (registered)
o_busy  out  1  high while in RUN
o_done  out  1  one-cycle pulse at end of run

Behaviour:
- Reset (async assert, sync release): o_data=RESET_VALUE, o_serial_out=0, o_busy=0, o_done=0, state=IDLE, internal count=0, latched mode=0.
- FSM states: IDLE, RUN, DONE.
- IDLE behaviour:
  - i_load=1: o_data<=i_load_data; i_start in the same cycle is ignored (load has priority).
  - Else i_start=1: latch i_mode and i_count.
    - count>0: go to RUN, remaining=count.
    - count=0: go directly to DONE with no shift.
- RUN behaviour:
  - One shift per clock; remaining decrements.
  - When remaining==1, perform the final shift and go to DONE.
  - For a start at edge E0 with count N, shifts occur at edges E1..EN. o_done is high in the cycle following EN.
  - i_load, i_start, i_mode and i_count are ignored while in RUN. o_busy=1 in RUN only.
- DONE behaviour: o_done=1 for exactly one cycle, then return to IDLE. i_start and i_load are ignored in DONE.
- Shift rules (q = o_data, W = WIDTH):
  - SHL: q<={q[W-2:0], i_serial_in}; serial_out<=q[W-1].
  - SHR: q<={i_serial_in, q[W-1:1]}; serial_out<=q[0].
  - ROL: q<={q[W-2:0], q[W-1]}; serial_out<=q[W-1].
  - LFSR: q<=(q>>1) ^ (q[0] ? LFSR_TAPS : 0); serial_out<=q[0].
  - LFSR lock-up: if q==0 at a LFSR shift, next q=1 (LSB set) and serial_out=0.
- o_serial_out holds its value when no shift occurs.
- Reset asserted mid-run: immediate return to the reset state. No o_done is issued.

Decomposition:
- Shared package bit_shift_pkg holds:
  - mode encodings (MODE_SHL=0, MODE_SHR=1, MODE_ROL=2, MODE_LFSR=3);
  - FSM state encodings;
  - default LFSR taps for WIDTH 8/16/32 (8'hB8, 16'hB400, 32'h80200003).
- One natural sub-module, bit_shift_step: purely combinational next-state/serial-out function of (q, mode, serial_in). The top module holds the FSM, counter and registers.

Test Plan:
- Reset release -> o_data=8'h01, o_busy=0, o_done=0, o_serial_out=0. Assert i_rst_n=0 mid-RUN -> same values immediately, and no done pulse.
- Load 8'h81, start SHL with count=3, i_serial_in=1 -> o_data sequence 8'h03, 8'h07, 8'h0F; serial_out 1,0,0; o_busy high 3 cycles; o_done pulse 1 cycle after the third shift.
- From reset value 8'h01, LFSR count=3 -> 8'hB8, 8'h5C, 8'h2E. Load 8'h00 then LFSR count=1 -> 8'h01.
- Load 8'h81, ROL count=8 -> o_data returns to 8'h81; o_done in cycle 9 after start. SHR 8'hF0 count=4 with serial_in=0 -> 8'h0F.
- Start with count=0 -> o_done next cycle, o_busy never high, o_data unchanged. Load and start in the same cycle -> data loaded, no run. Load or start during RUN -> ignored, final value unaffected.
